axi_rd_scheduler: RTL and testbench

//  Schedules the AXI read-address channel between the instruction cache and the data cache.

---
 rtl/axi_rd_scheduler_if.sv | 67 ++++++
 rtl/axi_rd_scheduler.sv | 178 +++++++++++++++++
 tb/tb_axi_rd_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_scheduler_if.sv
`timescale 1ns/1ps
// axi_rd_scheduler_if: cache-side AR/R ports, write snoop and outer AXI read port
interface axi_rd_scheduler_if;
    // I-cache side
    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        i_rvalid;
    logic        i_rready;
    // D-cache side
    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic        d_rvalid;
    logic        d_rready;
    // write-channel snoop
    logic [31:0] wr_awaddr;
    logic        wr_awfire;
    logic        wr_bfire;
    // outer AXI read-address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // outer AXI read-data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // scheduler view (it is the AXI read master)
    modport master (
        input  i_araddr, i_arlen, i_arvalid, i_rready,
        output i_arready, i_rdata, i_rlast, i_rvalid,
        input  d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
        output d_arready, d_rdata, d_rlast, d_rvalid,
        input  wr_awaddr, wr_awfire, wr_bfire,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rlast, rvalid,
        output rready
    );

    // environment view (caches, write path and AXI slave)
    modport slave (
        output i_araddr, i_arlen, i_arvalid, i_rready,
        input  i_arready, i_rdata, i_rlast, i_rvalid,
        output d_araddr, d_arlen, d_arsize, d_arvalid, d_rready,
        input  d_arready, d_rdata, d_rlast, d_rvalid,
        output wr_awaddr, wr_awfire, wr_bfire,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_scheduler.sv
`timescale 1ns/1ps
// axi_rd_scheduler: arbitrates I-/D-cache read requests onto one AXI AR channel
// (D first, starvation guard for I, RAW hold against an in-flight write line)
// and steers R beats back to the requester by rid.
module axi_rd_scheduler #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned LINE_OFF_W = 5
) (
    input logic                aclk,
    input logic                aresetn,
    axi_rd_scheduler_if.master bus
);
    localparam int unsigned      CNT_W      = $clog2(STARVE_MAX + 1);
    localparam int unsigned      LINE_W     = 32 - LINE_OFF_W;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_e;

    ar_state_e         state_q, state_d;
    logic              sel_d_q, sel_d_d;       // granted source: 1 = D, 0 = I
    logic [3:0]        arid_q, arid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [3:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              i_out_q, i_out_d;
    logic              d_out_q, d_out_d;
    logic              wr_out_q, wr_out_d;
    logic [LINE_W-1:0] wr_line_q, wr_line_d;

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic ar_fire;
    logic rready_w;
    logic r_done;

    assign i_elig = bus.i_arvalid & ~i_out_q;
    assign d_elig = bus.d_arvalid & ~d_out_q
                  & ~(wr_out_q & (bus.d_araddr[31:LINE_OFF_W] == wr_line_q));

    // D wins unless I has lost STARVE_MAX times in a row; D still takes an idle slot I cannot use
    assign grant_d = (state_q == AR_IDLE) & d_elig & ((starve_q < STARVE_LIM) | ~i_elig);
    assign grant_i = (state_q == AR_IDLE) & i_elig & ~grant_d;
    assign ar_fire = (state_q == AR_BUSY) & bus.arready;

    assign bus.arvalid   = (state_q == AR_BUSY);
    assign bus.arid      = arid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arlen     = arlen_q;
    assign bus.arsize    = arsize_q;
    assign bus.arburst   = 2'b01;
    assign bus.i_arready = ar_fire & ~sel_d_q;
    assign bus.d_arready = ar_fire & sel_d_q;

    // unknown rids are always accepted so a stray beat can never stall the bus
    assign rready_w     = (bus.rid == 4'd0) ? bus.i_rready :
                          (bus.rid == 4'd1) ? bus.d_rready : 1'b1;
    assign bus.rready   = rready_w;
    assign r_done       = bus.rvalid & rready_w & bus.rlast;
    assign bus.i_rvalid = bus.rvalid & (bus.rid == 4'd0);
    assign bus.d_rvalid = bus.rvalid & (bus.rid == 4'd1);
    assign bus.i_rdata  = bus.rdata;
    assign bus.d_rdata  = bus.rdata;
    assign bus.i_rlast  = bus.rlast;
    assign bus.d_rlast  = bus.rlast;

    // AR FSM next state and AR field capture on grant
    always_comb begin
        state_d  = state_q;
        sel_d_d  = sel_d_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        case (state_q)
            AR_IDLE: begin
                if (grant_d) begin
                    state_d  = AR_BUSY;
                    sel_d_d  = 1'b1;
                    arid_d   = 4'd1;
                    araddr_d = bus.d_araddr;
                    arlen_d  = bus.d_arlen;
                    arsize_d = bus.d_arsize;
                end else if (grant_i) begin
                    state_d  = AR_BUSY;
                    sel_d_d  = 1'b0;
                    arid_d   = 4'd0;
                    araddr_d = bus.i_araddr;
                    arlen_d  = bus.i_arlen;
                    arsize_d = 3'b010;
                end
            end
            AR_BUSY: begin
                if (bus.arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    // starvation counter, outstanding flags and write-line tracking
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d & i_elig & (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // a new AR acceptance takes precedence over a same-cycle burst completion
        i_out_d = i_out_q;
        if (r_done & (bus.rid == 4'd0)) begin
            i_out_d = 1'b0;
        end
        if (ar_fire & ~sel_d_q) begin
            i_out_d = 1'b1;
        end

        d_out_d = d_out_q;
        if (r_done & (bus.rid == 4'd1)) begin
            d_out_d = 1'b0;
        end
        if (ar_fire & sel_d_q) begin
            d_out_d = 1'b1;
        end

        wr_out_d  = wr_out_q;
        wr_line_d = wr_line_q;
        if (bus.wr_awfire) begin
            wr_out_d  = 1'b1;
            wr_line_d = bus.wr_awaddr[31:LINE_OFF_W];
        end else if (bus.wr_bfire) begin
            wr_out_d = 1'b0;
        end
    end

    // AR FSM state and held AR fields
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= AR_IDLE;
            sel_d_q  <= 1'b0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_d_q  <= sel_d_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
        end
    end

    // tracking registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            starve_q  <= '0;
            i_out_q   <= 1'b0;
            d_out_q   <= 1'b0;
            wr_out_q  <= 1'b0;
            wr_line_q <= '0;
        end else begin
            starve_q  <= starve_d;
            i_out_q   <= i_out_d;
            d_out_q   <= d_out_d;
            wr_out_q  <= wr_out_d;
            wr_line_q <= wr_line_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_scheduler.sv
`timescale 1ns/1ps
// tb_axi_rd_scheduler: directed scenarios plus randomized traffic against a
// rule-level reference model of the arbitration, RAW hold and R steering.
module tb_axi_rd_scheduler;
    localparam int STARVE_MAX = 8;
    localparam int LINE_OFF_W = 5;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_rd_scheduler_if bif ();

    axi_rd_scheduler #(
        .STARVE_MAX (STARVE_MAX),
        .LINE_OFF_W (LINE_OFF_W)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bif)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: one pending AR at most, per-source outstanding bursts
    bit          m_busy;
    int          m_src;
    logic [31:0] m_addr;
    logic [3:0]  m_len;
    logic [2:0]  m_size;
    bit          m_out [2];
    int          beats [2];
    bit          m_wr;
    logic [31:0] m_wr_addr;
    int          m_lost;
    bit          ev_acc_i;
    bit          ev_acc_d;

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a >> LINE_OFF_W) == (b >> LINE_OFF_W);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_src = 0; m_addr = '0; m_len = '0; m_size = '0;
        m_out[0] = 0; m_out[1] = 0; beats[0] = 0; beats[1] = 0;
        m_wr = 0; m_wr_addr = '0; m_lost = 0; ev_acc_i = 0; ev_acc_d = 0;
    endtask

    task automatic clear_inputs();
        bif.i_araddr = '0; bif.i_arlen = '0; bif.i_arvalid = 0; bif.i_rready = 0;
        bif.d_araddr = '0; bif.d_arlen = '0; bif.d_arsize = '0; bif.d_arvalid = 0; bif.d_rready = 0;
        bif.wr_awaddr = '0; bif.wr_awfire = 0; bif.wr_bfire = 0;
        bif.arready = 0; bif.rid = '0; bif.rdata = '0; bif.rlast = 0; bif.rvalid = 0;
    endtask

    // one clock: check all outputs against the model, advance the model, cross the edge
    task automatic step();
        logic exp_rready;
        bit   ie, de;
        int   win, r;
        #1;
        exp_rready = (bif.rid == 4'd0) ? bif.i_rready : ((bif.rid == 4'd1) ? bif.d_rready : 1'b1);
        chk("arvalid",   32'(bif.arvalid), 32'(m_busy));
        chk("arid",      32'(bif.arid), 32'(m_src));
        chk("araddr",    bif.araddr, m_addr);
        chk("arlen",     32'(bif.arlen), 32'(m_len));
        chk("arsize",    32'(bif.arsize), 32'(m_size));
        chk("arburst",   32'(bif.arburst), 32'd1);
        chk("i_arready", 32'(bif.i_arready), 32'(m_busy && bif.arready && m_src == 0));
        chk("d_arready", 32'(bif.d_arready), 32'(m_busy && bif.arready && m_src == 1));
        chk("i_rvalid",  32'(bif.i_rvalid), 32'(bif.rvalid && bif.rid == 4'd0));
        chk("d_rvalid",  32'(bif.d_rvalid), 32'(bif.rvalid && bif.rid == 4'd1));
        chk("rready",    32'(bif.rready), 32'(exp_rready));
        chk("i_rdata",   bif.i_rdata, bif.rdata);
        chk("d_rdata",   bif.d_rdata, bif.rdata);
        chk("r_last",    32'({bif.i_rlast, bif.d_rlast}), 32'({bif.rlast, bif.rlast}));

        ev_acc_i = m_busy && bif.arready && m_src == 0;
        ev_acc_d = m_busy && bif.arready && m_src == 1;
        ie  = bif.i_arvalid && !m_out[0];
        de  = bif.d_arvalid && !m_out[1] && !(m_wr && same_line(bif.d_araddr, m_wr_addr));
        win = -1;
        if (!m_busy) begin
            if (de && m_lost < STARVE_MAX) win = 1;
            else if (ie)                   win = 0;
            else if (de)                   win = 1;
        end
        r = int'(bif.rid);
        if (bif.rvalid && exp_rready && r < 2) begin
            if (beats[r] > 0) beats[r]--;
            if (bif.rlast) m_out[r] = 0;
        end
        if (ev_acc_i || ev_acc_d) begin
            m_out[m_src] = 1;
            beats[m_src] = int'(m_len) + 1;
            m_busy = 0;
        end
        if (win == 1) begin
            m_busy = 1; m_src = 1;
            m_addr = bif.d_araddr; m_len = bif.d_arlen; m_size = bif.d_arsize;
            if (ie) m_lost = (m_lost < STARVE_MAX) ? m_lost + 1 : STARVE_MAX;
        end else if (win == 0) begin
            m_busy = 1; m_src = 0;
            m_addr = bif.i_araddr; m_len = bif.i_arlen; m_size = 3'b010;
            m_lost = 0;
        end
        if (bif.wr_awfire) begin
            m_wr = 1; m_wr_addr = bif.wr_awaddr;
        end else if (bif.wr_bfire) begin
            m_wr = 0;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic reset_dut();
        clear_inputs();
        bif.arready = 1;
        aresetn = 0;
        #1;
        chk("rst_arvalid",   32'(bif.arvalid), 32'd0);
        chk("rst_araddr",    bif.araddr, 32'd0);
        chk("rst_arid",      32'(bif.arid), 32'd0);
        chk("rst_arlen",     32'(bif.arlen), 32'd0);
        chk("rst_arsize",    32'(bif.arsize), 32'd0);
        chk("rst_arburst",   32'(bif.arburst), 32'd1);
        chk("rst_i_arready", 32'(bif.i_arready), 32'd0);
        chk("rst_d_arready", 32'(bif.d_arready), 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1;
        bif.arready = 0;
    endtask

    task automatic rand_drive();
        int id;
        bif.i_arvalid = ($urandom_range(0, 2) != 0);
        bif.i_araddr  = $urandom;
        bif.i_arlen   = 4'($urandom_range(0, 3));
        bif.d_arvalid = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 3))
            0:       bif.d_araddr = (m_wr_addr & ~32'h1f) | ($urandom & 32'h1f);
            1:       bif.d_araddr = 32'h1000_0000 | ($urandom & 32'h1ff);
            default: bif.d_araddr = $urandom;
        endcase
        bif.d_arlen  = 4'($urandom_range(0, 3));
        bif.d_arsize = 3'($urandom);
        bif.wr_awaddr = 32'h1000_0000 | ($urandom & 32'h1ff);
        if (!m_wr) begin
            bif.wr_awfire = ($urandom_range(0, 4) == 0);
            bif.wr_bfire  = 0;
        end else begin
            bif.wr_bfire  = ($urandom_range(0, 5) == 0);
            bif.wr_awfire = bif.wr_bfire && ($urandom_range(0, 1) == 1);
        end
        bif.arready  = ($urandom_range(0, 2) != 0);
        bif.i_rready = ($urandom_range(0, 1) == 1);
        bif.d_rready = ($urandom_range(0, 1) == 1);
        bif.rdata    = $urandom;
        bif.rid      = 4'($urandom);
        bif.rlast    = 0;
        bif.rvalid   = 0;
        case ($urandom_range(0, 7))
            0: begin
                bif.rid    = 4'($urandom_range(2, 15));
                bif.rlast  = ($urandom_range(0, 1) == 1);
                bif.rvalid = 1;
            end
            1, 2, 3, 4: begin
                id = -1;
                if (beats[0] > 0 && beats[1] > 0) id = $urandom_range(0, 1);
                else if (beats[0] > 0)            id = 0;
                else if (beats[1] > 0)            id = 1;
                if (id >= 0) begin
                    bif.rid    = 4'(id);
                    bif.rlast  = (beats[id] == 1);
                    bif.rvalid = 1;
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d_wins;
        bit  got_i;

        clear_inputs();
        reset_dut();

        // reset in the middle of traffic: D outstanding, I request on the bus
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_1100; bif.d_arlen = 4'd2; bif.d_arsize = 3'd3;
        bif.arready = 1;
        step();
        step();
        bif.d_arvalid = 0;
        bif.i_arvalid = 1; bif.i_araddr = 32'h0000_2200; bif.arready = 0;
        step();
        chk("t1_pre_arvalid", 32'(bif.arvalid), 32'd1);
        reset_dut();
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_3300;
        step();
        chk("t1_post_arvalid", 32'(bif.arvalid), 32'd1);
        chk("t1_post_arid",    32'(bif.arid), 32'd1);

        // simultaneous I and D requests
        reset_dut();
        bif.i_arvalid = 1; bif.i_araddr = 32'h0000_2000; bif.i_arlen = 4'd3;
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_3000; bif.d_arlen = 4'd7; bif.d_arsize = 3'd3;
        bif.arready = 1;
        step();
        chk("t2_d_arvalid",  32'(bif.arvalid), 32'd1);
        chk("t2_d_arid",     32'(bif.arid), 32'd1);
        chk("t2_d_arready",  32'(bif.d_arready), 32'd1);
        bif.d_arvalid = 0;
        step();
        step();
        chk("t2_i_arid",     32'(bif.arid), 32'd0);
        chk("t2_i_arsize",   32'(bif.arsize), 32'd2);
        chk("t2_i_arlen",    32'(bif.arlen), 32'd3);
        chk("t2_i_arready",  32'(bif.i_arready), 32'd1);
        step();

        // starvation: I only competes when D is free to win, so only the guard lets it through
        reset_dut();
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_4000; bif.d_arlen = 4'd0; bif.d_rready = 1;
        bif.i_araddr = 32'h0000_5000; bif.arready = 1;
        d_wins = 0;
        got_i  = 0;
        for (int c = 0; c < 80 && !got_i; c++) begin
            bif.i_arvalid = !m_out[1];
            bif.rvalid = (beats[1] > 0);
            bif.rid    = 4'd1;
            bif.rlast  = 1;
            step();
            if (ev_acc_i)      got_i = 1;
            else if (ev_acc_d) d_wins++;
        end
        chk("t3_i_granted", 32'(got_i), 32'd1);
        chk("t3_d_wins",    32'(d_wins), 32'(STARVE_MAX));

        // RAW hold on the in-flight write line
        reset_dut();
        bif.wr_awaddr = 32'h1000_0040; bif.wr_awfire = 1;
        step();
        bif.wr_awfire = 0;
        bif.d_arvalid = 1; bif.d_araddr = 32'h1000_0054; bif.arready = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_raw_hold", 32'(bif.arvalid), 32'd0);
        end
        bif.wr_bfire = 1;
        step();
        chk("t4_bfire_cycle", 32'(bif.arvalid), 32'd0);
        bif.wr_bfire = 0;
        step();
        chk("t4_after_b_arvalid", 32'(bif.arvalid), 32'd1);
        chk("t4_after_b_araddr",  bif.araddr, 32'h1000_0054);
        reset_dut();
        bif.wr_awaddr = 32'h1000_0040; bif.wr_awfire = 1;
        step();
        bif.wr_awfire = 0;
        bif.d_arvalid = 1; bif.d_araddr = 32'h1000_0060;
        step();
        chk("t4_other_line", 32'(bif.arvalid), 32'd1);

        // R routing with interleaved ids
        reset_dut();
        bif.i_arvalid = 1; bif.i_araddr = 32'h0000_6000; bif.i_arlen = 4'd1;
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_7000; bif.d_arlen = 4'd1;
        bif.arready = 1;
        step();
        bif.d_arvalid = 0;
        step();
        step();
        bif.i_arvalid = 0;
        step();
        bif.i_rready = 0; bif.d_rready = 1; bif.rvalid = 1;
        bif.rid = 4'd0; bif.rlast = 0; bif.rdata = 32'hA0A0_0000;
        step();
        bif.rid = 4'd1; bif.rdata = 32'hD1D1_0001;
        step();
        bif.rid = 4'd0; bif.rdata = 32'hA0A0_0002;
        step();
        bif.rid = 4'd1; bif.rlast = 1; bif.rdata = 32'hD1D1_0003;
        step();
        bif.rvalid = 0; bif.rlast = 0;
        bif.i_arvalid = 1;
        step();
        chk("t5_i_still_out", 32'(bif.arvalid), 32'd0);
        bif.i_arvalid = 0;
        bif.d_arvalid = 1; bif.d_araddr = 32'h0000_7100;
        step();
        chk("t5_d_cleared_arvalid", 32'(bif.arvalid), 32'd1);
        chk("t5_d_cleared_arid",    32'(bif.arid), 32'd1);

        // AR stall: fields stable, no accept pulse until handshake
        reset_dut();
        bif.i_arvalid = 1; bif.i_araddr = 32'hABCD_0000; bif.i_arlen = 4'd5; bif.arready = 0;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("t6_stall_araddr",    bif.araddr, 32'hABCD_0000);
            chk("t6_stall_arlen",     32'(bif.arlen), 32'd5);
            chk("t6_stall_i_arready", 32'(bif.i_arready), 32'd0);
            step();
        end
        bif.arready = 1;
        #1;
        chk("t6_handshake_pulse", 32'(bif.i_arready), 32'd1);
        step();
        chk("t6_after_handshake", 32'(bif.arvalid), 32'd0);

        // randomized traffic
        reset_dut();
        for (int c = 0; c < 4000; c++) begin
            rand_drive();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
